// File: rtl/isu_pkg.sv
// Shared ISU types: packed issue-queue uop payload and the ROB age compare.
package isu_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [3:0]  cx_type;
        logic [4:0]  alu_type;
        logic [2:0]  muldiv_type;
        logic [7:0]  flags;
        logic [1:0]  ls_size;
        logic [5:0]  prd;
        logic [5:0]  old_prd;
        logic        predict_taken;
        logic [55:0] predict_target;
        logic [4:0]  sqid;
    } iq_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(iq_payload_t);

    // a and b are zero-extended robids of width w; the MSB is the wrap bit.
    function automatic logic robid_older(input logic [31:0] a, input logic [31:0] b,
                                         input int unsigned w);
        logic [31:0] mask;
        logic [31:0] a_wrap;
        logic [31:0] b_wrap;
        mask   = (32'd1 << (w - 1)) - 32'd1;
        a_wrap = (a >> (w - 1)) & 32'd1;
        b_wrap = (b >> (w - 1)) & 32'd1;
        if (a_wrap == b_wrap) begin
            return (a & mask) < (b & mask);
        end
        return (a & mask) > (b & mask);
    endfunction

endpackage

// File: rtl/iq_oldest_select.sv
// Issue-queue select: one-hot grant over ready entries.
// IQ_AGE_SELECT_EN picks the oldest robid; otherwise the lowest index wins.
module iq_oldest_select
    import isu_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ROBID_W = 7
) (
    input  logic [DEPTH-1:0]              ready,
    input  logic [DEPTH-1:0][ROBID_W-1:0] robid,
    output logic [DEPTH-1:0]              grant,
    output logic                          any_ready
);

    assign any_ready = |ready;

`ifdef IQ_AGE_SELECT_EN
    logic               found;
    logic [ROBID_W-1:0] best_robid;

    always_comb begin
        grant      = '0;
        found      = 1'b0;
        best_robid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!found ||
                    robid_older(32'(robid[i]), 32'(best_robid), ROBID_W))) begin
                grant      = '0;
                grant[i]   = 1'b1;
                found      = 1'b1;
                best_robid = robid[i];
            end
        end
    end
`else
    logic found;
    logic unused_robid;

    assign unused_robid = ^robid;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/iq_window.sv
// Multi-entry issue queue: holds renamed uops until both sources wake, issues one per cycle.
// Select policy is chosen by IQ_AGE_SELECT_EN (see iq_oldest_select).
module iq_window #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WB_PORTS  = 4,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned ROBID_W   = 7,
    parameter int unsigned PAYLOAD_W = isu_pkg::PAYLOAD_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [PREG_W-1:0]          enq_prs1,
    input  logic [PREG_W-1:0]          enq_prs2,
    input  logic                       enq_src1_busy,
    input  logic                       enq_src2_busy,
    input  logic [ROBID_W-1:0]         enq_robid,
    input  logic [PAYLOAD_W-1:0]       enq_payload,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0] wb_prd,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [PREG_W-1:0]          issue_prs1,
    output logic [PREG_W-1:0]          issue_prs2,
    output logic [ROBID_W-1:0]         issue_robid,
    output logic [PAYLOAD_W-1:0]       issue_payload,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0]                busy1_q, busy1_d;
    logic [DEPTH-1:0]                busy2_q, busy2_d;
    logic [DEPTH-1:0][PREG_W-1:0]    prs1_q, prs2_q;
    logic [DEPTH-1:0][ROBID_W-1:0]   robid_q;
    logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_q;
    logic [CNT_W-1:0]                count_q, count_d;

    logic [DEPTH-1:0] wake1, wake2, ready, grant, enq_sel;
    logic             enq_wake1, enq_wake2, enq_found;
    logic             any_ready, enq_fire, issue_fire;

    always_comb begin
        wake1     = '0;
        wake2     = '0;
        enq_wake1 = 1'b0;
        enq_wake2 = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wb_prd[k*PREG_W +: PREG_W] == prs1_q[i]) wake1[i] = 1'b1;
                    if (wb_prd[k*PREG_W +: PREG_W] == prs2_q[i]) wake2[i] = 1'b1;
                end
                // Catch a broadcast that lands in the same cycle as dispatch.
                if (wb_prd[k*PREG_W +: PREG_W] == enq_prs1) enq_wake1 = 1'b1;
                if (wb_prd[k*PREG_W +: PREG_W] == enq_prs2) enq_wake2 = 1'b1;
            end
        end
    end

    always_comb begin
        enq_sel   = '0;
        enq_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !enq_found) begin
                enq_sel[i] = 1'b1;
                enq_found  = 1'b1;
            end
        end
    end

    assign ready       = valid_q & ~busy1_q & ~busy2_q;
    assign enq_ready   = ~&valid_q;
    assign enq_fire    = enq_valid & enq_ready;
    assign issue_valid = any_ready & ~flush;
    assign issue_fire  = issue_valid & issue_ready;
    assign count       = count_q;

    iq_oldest_select #(
        .DEPTH   (DEPTH),
        .ROBID_W (ROBID_W)
    ) u_select (
        .ready     (ready),
        .robid     (robid_q),
        .grant     (grant),
        .any_ready (any_ready)
    );

    always_comb begin
        valid_d = valid_q;
        busy1_d = busy1_q & ~wake1;
        busy2_d = busy2_q & ~wake2;
        count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);
        if (issue_fire) valid_d = valid_d & ~grant;
        if (enq_fire) begin
            valid_d = valid_d | enq_sel;
            busy1_d = (busy1_d & ~enq_sel) | ({DEPTH{enq_src1_busy & ~enq_wake1}} & enq_sel);
            busy2_d = (busy2_d & ~enq_sel) | ({DEPTH{enq_src2_busy & ~enq_wake2}} & enq_sel);
        end
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            busy1_q <= '0;
            busy2_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            busy1_q <= busy1_d;
            busy2_q <= busy2_d;
            count_q <= count_d;
        end
    end

    // Data fields are qualified by valid_q, so they need no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_fire && enq_sel[i]) begin
                prs1_q[i]    <= enq_prs1;
                prs2_q[i]    <= enq_prs2;
                robid_q[i]   <= enq_robid;
                payload_q[i] <= enq_payload;
            end
        end
    end

    always_comb begin
        issue_prs1    = '0;
        issue_prs2    = '0;
        issue_robid   = '0;
        issue_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_prs1    = issue_prs1 | prs1_q[i];
                issue_prs2    = issue_prs2 | prs2_q[i];
                issue_robid   = issue_robid | robid_q[i];
                issue_payload = issue_payload | payload_q[i];
            end
        end
    end

endmodule

// File: tb/tb_iq_window.sv
// Directed bench for iq_window with a scoreboard of expected issue order.
module tb_iq_window;

    localparam int DEPTH     = 8;
    localparam int WB_PORTS  = 4;
    localparam int PREG_W    = 6;
    localparam int ROBID_W   = 7;
    localparam int PAYLOAD_W = 256;

    logic                       clock;
    logic                       reset;
    logic                       enq_valid;
    logic                       enq_ready;
    logic [PREG_W-1:0]          enq_prs1, enq_prs2;
    logic                       enq_src1_busy, enq_src2_busy;
    logic [ROBID_W-1:0]         enq_robid;
    logic [PAYLOAD_W-1:0]       enq_payload;
    logic [WB_PORTS-1:0]        wb_valid;
    logic [WB_PORTS*PREG_W-1:0] wb_prd;
    logic                       issue_valid;
    logic                       issue_ready;
    logic [PREG_W-1:0]          issue_prs1, issue_prs2;
    logic [ROBID_W-1:0]         issue_robid;
    logic [PAYLOAD_W-1:0]       issue_payload;
    logic                       flush;
    logic [$clog2(DEPTH):0]     count;

    iq_window #(
        .DEPTH     (DEPTH),
        .WB_PORTS  (WB_PORTS),
        .PREG_W    (PREG_W),
        .ROBID_W   (ROBID_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enq_valid     (enq_valid),
        .enq_ready     (enq_ready),
        .enq_prs1      (enq_prs1),
        .enq_prs2      (enq_prs2),
        .enq_src1_busy (enq_src1_busy),
        .enq_src2_busy (enq_src2_busy),
        .enq_robid     (enq_robid),
        .enq_payload   (enq_payload),
        .wb_valid      (wb_valid),
        .wb_prd        (wb_prd),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_prs1    (issue_prs1),
        .issue_prs2    (issue_prs2),
        .issue_robid   (issue_robid),
        .issue_payload (issue_payload),
        .flush         (flush),
        .count         (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [ROBID_W-1:0] robid;
        logic [PREG_W-1:0]  prs1;
        logic [PREG_W-1:0]  prs2;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fails   = 0;

    function automatic logic [PAYLOAD_W-1:0] mk_payload(input logic [ROBID_W-1:0] r);
        return {8{25'h1ABCDEF, r}};
    endfunction

    task automatic check(input string tag, input logic [PAYLOAD_W-1:0] obs,
                         input logic [PAYLOAD_W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_enq(input logic [PREG_W-1:0] p1, input logic b1,
                           input logic [PREG_W-1:0] p2, input logic b2,
                           input logic [ROBID_W-1:0] r);
        enq_valid     = 1'b1;
        enq_prs1      = p1;
        enq_src1_busy = b1;
        enq_prs2      = p2;
        enq_src2_busy = b2;
        enq_robid     = r;
        enq_payload   = mk_payload(r);
    endtask

    task automatic enq(input logic [PREG_W-1:0] p1, input logic b1,
                       input logic [PREG_W-1:0] p2, input logic b2,
                       input logic [ROBID_W-1:0] r);
        set_enq(p1, b1, p2, b2, r);
        step();
        enq_valid = 1'b0;
    endtask

    task automatic wb(input int port, input logic [PREG_W-1:0] tag);
        wb_valid[port]                = 1'b1;
        wb_prd[port*PREG_W +: PREG_W] = tag;
    endtask

    task automatic push(input logic [ROBID_W-1:0] r, input logic [PREG_W-1:0] p1,
                        input logic [PREG_W-1:0] p2);
        exp_t e;
        e.robid = r;
        e.prs1  = p1;
        e.prs2  = p2;
        sb.push_back(e);
    endtask

    // Compare the shown uop with the scoreboard head; pop it only if accepted.
    task automatic issue_check(input string tag, input bit accept);
        exp_t e;
        check({tag, "_valid"}, issue_valid, 1);
        if (sb.size() == 0) begin
            n_asserts++;
            n_fails++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb[0];
            check({tag, "_robid"}, issue_robid, e.robid);
            check({tag, "_prs1"}, issue_prs1, e.prs1);
            check({tag, "_prs2"}, issue_prs2, e.prs2);
            check({tag, "_payload"}, issue_payload, mk_payload(e.robid));
            if (accept) begin
                issue_ready = 1'b1;
                step();
                issue_ready = 1'b0;
                void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        enq_valid     = 1'b0;
        enq_prs1      = '0;
        enq_prs2      = '0;
        enq_src1_busy = 1'b0;
        enq_src2_busy = 1'b0;
        enq_robid     = '0;
        enq_payload   = '0;
        wb_valid      = '0;
        wb_prd        = '0;
        issue_ready   = 1'b0;
        flush         = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        #1;
        check("rst_enq_ready", enq_ready, 1);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_count", count, 0);
        check("rst_robid", issue_robid, 0);
        check("rst_prs1", issue_prs1, 0);
        check("rst_payload", issue_payload, 0);
        step();

        // Wakeup of a stored entry: ready one cycle after the broadcast.
        enq(6'd5, 1'b1, 6'd7, 1'b0, 7'd3);
        push(7'd3, 6'd5, 6'd7);
        check("t1_wait_valid", issue_valid, 0);
        check("t1_count", count, 1);
        wb(0, 6'd5);
        wb(3, 6'd5);
        #1;
        check("t1_wb_cycle_valid", issue_valid, 0);
        step();
        wb_valid = '0;
        issue_check("t1", 1'b1);
        check("t1_after_count", count, 0);
        check("t1_after_valid", issue_valid, 0);

        // Broadcast in the dispatch cycle must not be lost.
        wb(2, 6'd9);
        enq(6'd9, 1'b1, 6'd10, 1'b0, 7'd4);
        wb_valid = '0;
        push(7'd4, 6'd9, 6'd10);
        issue_check("t2", 1'b1);

        // Select policy across a robid wrap.
        enq(6'd1, 1'b0, 6'd2, 1'b0, 7'h41);
        enq(6'd3, 1'b0, 6'd4, 1'b0, 7'h3E);
`ifdef IQ_AGE_SELECT_EN
        push(7'h3E, 6'd3, 6'd4);
        push(7'h41, 6'd1, 6'd2);
`else
        push(7'h41, 6'd1, 6'd2);
        push(7'h3E, 6'd3, 6'd4);
`endif
        issue_check("t3_hold", 1'b0);
        issue_check("t3_first", 1'b1);
        issue_check("t3_second", 1'b1);
        check("t3_count", count, 0);

        // Fill, then issue with enqueue held: slot reusable only a cycle later.
        for (int i = 0; i < DEPTH; i++) begin
            enq(6'd30, 1'b1, 6'd0, 1'b0, 7'(16 + i));
        end
        check("t4_full_count", count, 8);
        check("t4_full_enq_ready", enq_ready, 0);
        check("t4_full_issue_valid", issue_valid, 0);
        wb(1, 6'd30);
        step();
        wb_valid = '0;
        set_enq(6'd31, 1'b1, 6'd0, 1'b0, 7'd24);
        check("t4_issue_cycle_enq_ready", enq_ready, 0);
        push(7'd16, 6'd30, 6'd0);
        issue_check("t4_first", 1'b1);
        check("t4_after_issue_count", count, 7);
        check("t4_after_issue_enq_ready", enq_ready, 1);
        step();
        enq_valid = 1'b0;
        check("t4_refill_count", count, 8);
        check("t4_refill_enq_ready", enq_ready, 0);
        push(7'd17, 6'd30, 6'd0);
        issue_check("t4_second", 1'b1);
        check("t4_second_count", count, 7);

        // Flush beats same-cycle enqueue and issue.
        set_enq(6'd11, 1'b0, 6'd12, 1'b0, 7'd40);
        issue_ready = 1'b1;
        flush       = 1'b1;
        #1;
        check("t5_flush_issue_valid", issue_valid, 0);
        check("t5_flush_enq_ready", enq_ready, 1);
        step();
        flush       = 1'b0;
        enq_valid   = 1'b0;
        issue_ready = 1'b0;
        sb.delete();
        check("t5_count", count, 0);
        check("t5_issue_valid", issue_valid, 0);
        step();
        check("t5_late_issue_valid", issue_valid, 0);
        check("t5_late_count", count, 0);

        // Asynchronous reset with waiting entries.
        for (int i = 0; i < 5; i++) begin
            enq(6'd33, 1'b1, 6'd34, 1'b0, 7'(50 + i));
        end
        check("t6_count_before", count, 5);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_issue_valid", issue_valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_enq_ready", enq_ready, 1);
        step();
        reset = 1'b0;
        wb(0, 6'd33);
        step();
        wb_valid = '0;
        check("t6_post_issue_valid", issue_valid, 0);
        check("t6_post_count", count, 0);
        check("t6_post_robid", issue_robid, 0);
        check("t6_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
